// File: rtl/dram_arb_if.sv
// Bundle between the cores, the arbiter and the shared DRAM port.
// Handshake: a core holds core_req (with we/addr/wdata stable) until its one-cycle core_gnt; reads then wait for a one-cycle core_rvalid.
interface dram_arb_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NCORES     = 4
);
  logic [NCORES-1:0]            core_req;
  logic [NCORES-1:0]            core_we;
  logic [NCORES*ADDR_WIDTH-1:0] core_addr;
  logic [NCORES*WIDTH-1:0]      core_wdata;
  logic [NCORES-1:0]            core_gnt;
  logic [NCORES-1:0]            core_rvalid;
  logic [WIDTH-1:0]             core_rdata;
  logic [ADDR_WIDTH-1:0]        DRAM_addr;
  logic [WIDTH-1:0]             DRAM_dataOut;
  logic [WIDTH-1:0]             DRAM_dataIn;
  logic                         memREAD;
  logic                         memWRITE;

  modport master (
    output core_req, core_we, core_addr, core_wdata, DRAM_dataIn,
    input  core_gnt, core_rvalid, core_rdata, DRAM_addr, DRAM_dataOut, memREAD, memWRITE
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, DRAM_dataIn,
    output core_gnt, core_rvalid, core_rdata, DRAM_addr, DRAM_dataOut, memREAD, memWRITE
  );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin front end serialising NCORES core requests onto one DRAM port,
// one outstanding transaction at a time, with a fixed read latency.
module dram_arbiter #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NCORES     = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                       Clk,
  input  logic                       Rst,
  dram_arb_if.slave                  bus,
  output logic [1:0]                 dbg_state_o,
  output logic [$clog2(NCORES)-1:0]  dbg_rr_ptr_o
);
  localparam int PW = $clog2(NCORES);
  localparam int CW = 4;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]         win_q, win_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NCORES-1:0]     rvalid_q, rvalid_d;

  logic [ADDR_WIDTH-1:0] addr_arr  [NCORES];
  logic [WIDTH-1:0]      wdata_arr [NCORES];
  logic                  hit;
  logic [PW-1:0]         pick;
  logic [PW:0]           probe;
  logic [NCORES-1:0]     win_onehot;

  always_comb begin
    for (int i = 0; i < NCORES; i++) begin
      addr_arr[i]  = bus.core_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = bus.core_wdata[i*WIDTH +: WIDTH];
    end
  end

  // Probe indices rr_ptr, rr_ptr+1, ... wrapping modulo NCORES; first hit wins.
  always_comb begin
    hit   = 1'b0;
    pick  = rr_ptr_q;
    probe = '0;
    for (int k = 0; k < NCORES; k++) begin
      probe = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (probe >= (PW+1)'(NCORES)) probe = probe - (PW+1)'(NCORES);
      if (!hit && bus.core_req[probe[PW-1:0]]) begin
        hit  = 1'b1;
        pick = probe[PW-1:0];
      end
    end
  end

  assign win_onehot = NCORES'(1) << win_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    rvalid_d = '0;
    case (state_q)
      ARB: begin
        if (hit) begin
          win_d    = pick;
          we_d     = bus.core_we[pick];
          addr_d   = addr_arr[pick];
          wdata_d  = wdata_arr[pick];
          rr_ptr_d = (pick == PW'(NCORES-1)) ? '0 : pick + 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = ARB;
        end else begin
          cnt_d   = CW'(RD_LATENCY);
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          rdata_d  = bus.DRAM_dataIn;
          rvalid_d = win_onehot;
          state_d  = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
      win_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  // addr_q/wdata_q only change on a new win, so they double as the held DRAM bus.
  assign bus.core_gnt     = (state_q == ISSUE) ? win_onehot : '0;
  assign bus.memWRITE     = (state_q == ISSUE) && we_q;
  assign bus.memREAD      = (state_q == ISSUE) && !we_q;
  assign bus.DRAM_addr    = addr_q;
  assign bus.DRAM_dataOut = wdata_q;
  assign bus.core_rdata   = rdata_q;
  assign bus.core_rvalid  = rvalid_q;

  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: a cycle table for reset, writes, a read and
// round-robin order, then hand sequences for reset mid-read and read latency.
module tb_dram_arbiter;
  localparam int W  = 8;
  localparam int AW = 8;
  localparam int NC = 4;
  localparam int RL = 2;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [1:0] dbg_state;
  logic [1:0] dbg_rr;

  dram_arb_if #(.WIDTH(W), .ADDR_WIDTH(AW), .NCORES(NC)) bus ();

  dram_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .NCORES(NC), .RD_LATENCY(RL)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .bus          (bus),
    .dbg_state_o  (dbg_state),
    .dbg_rr_ptr_o (dbg_rr)
  );

  always #5 Clk = ~Clk;

  // exp = {gnt, rvalid, memREAD, memWRITE, DRAM_addr, DRAM_dataOut, core_rdata, state, rr_ptr}
  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [7:0]  din;
    logic [37:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] we,
                     input logic [7:0] din, input logic [3:0] gnt, input logic [3:0] rv,
                     input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] rdat, input logic [1:0] st, input logic [1:0] rr);
    vec_t v;
    v.rst = rst; v.req = req; v.we = we; v.din = din;
    v.exp = {gnt, rv, rd, wr, a, d, rdat, st, rr};
    vecs.push_back(v);
  endtask

  function automatic logic [37:0] obs();
    return {bus.core_gnt, bus.core_rvalid, bus.memREAD, bus.memWRITE, bus.DRAM_addr,
            bus.DRAM_dataOut, bus.core_rdata, dbg_state, dbg_rr};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    logic [3:0] rv_seen;
    logic [3:0] rv_val;
    logic [7:0] rd_val;
    int         lat;
    bit         got;

    bus.core_req    = '0;
    bus.core_we     = '0;
    bus.core_addr   = {8'h30, 8'h10, 8'h20, 8'h40};
    bus.core_wdata  = {8'h33, 8'hA5, 8'h22, 8'h11};
    bus.DRAM_dataIn = '0;

    //  rst req  we   din    gnt  rv   rd wr addr   dout   rdata  st rr
    add(1, 4'hF, 4'hF, 8'h00, 4'h0, 4'h0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    add(1, 4'hF, 4'hF, 8'h00, 4'h0, 4'h0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 4'hF, 4'hF, 8'h00, 4'h0, 4'h0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    add(0, 4'hE, 4'hF, 8'h00, 4'h1, 4'h0, 0, 1, 8'h40, 8'h11, 8'h00, 1, 1);
    add(0, 4'hE, 4'hF, 8'h00, 4'h0, 4'h0, 0, 0, 8'h40, 8'h11, 8'h00, 0, 1);
    add(0, 4'hC, 4'hF, 8'h00, 4'h2, 4'h0, 0, 1, 8'h20, 8'h22, 8'h00, 1, 2);
    add(0, 4'hC, 4'hF, 8'h00, 4'h0, 4'h0, 0, 0, 8'h20, 8'h22, 8'h00, 0, 2);
    add(0, 4'h8, 4'hF, 8'h00, 4'h4, 4'h0, 0, 1, 8'h10, 8'hA5, 8'h00, 1, 3);
    add(0, 4'h8, 4'hF, 8'h00, 4'h0, 4'h0, 0, 0, 8'h10, 8'hA5, 8'h00, 0, 3);
    add(0, 4'h0, 4'hF, 8'h00, 4'h8, 4'h0, 0, 1, 8'h30, 8'h33, 8'h00, 1, 0);
    // single write from core 2
    add(0, 4'h4, 4'hF, 8'h00, 4'h0, 4'h0, 0, 0, 8'h30, 8'h33, 8'h00, 0, 0);
    add(0, 4'h0, 4'hF, 8'h00, 4'h4, 4'h0, 0, 1, 8'h10, 8'hA5, 8'h00, 1, 3);
    add(0, 4'h0, 4'hF, 8'h00, 4'h0, 4'h0, 0, 0, 8'h10, 8'hA5, 8'h00, 0, 3);
    // core 1 read, DRAM returns 0x3C
    add(0, 4'h2, 4'h0, 8'h00, 4'h0, 4'h0, 0, 0, 8'h10, 8'hA5, 8'h00, 0, 3);
    add(0, 4'h0, 4'h0, 8'h00, 4'h2, 4'h0, 1, 0, 8'h20, 8'h22, 8'h00, 1, 2);
    add(0, 4'h0, 4'h0, 8'h3C, 4'h0, 4'h0, 0, 0, 8'h20, 8'h22, 8'h00, 2, 2);
    add(0, 4'h0, 4'h0, 8'h3C, 4'h0, 4'h0, 0, 0, 8'h20, 8'h22, 8'h00, 2, 2);
    add(0, 4'h0, 4'h0, 8'h00, 4'h0, 4'h2, 0, 0, 8'h20, 8'h22, 8'h3C, 0, 2);
    // fairness: core 3 continuous, core 1 once
    add(0, 4'h8, 4'hF, 8'h00, 4'h0, 4'h0, 0, 0, 8'h20, 8'h22, 8'h3C, 0, 2);
    add(0, 4'hA, 4'hF, 8'h00, 4'h8, 4'h0, 0, 1, 8'h30, 8'h33, 8'h3C, 1, 0);
    add(0, 4'hA, 4'hF, 8'h00, 4'h0, 4'h0, 0, 0, 8'h30, 8'h33, 8'h3C, 0, 0);
    add(0, 4'h8, 4'hF, 8'h00, 4'h2, 4'h0, 0, 1, 8'h20, 8'h22, 8'h3C, 1, 2);
    add(0, 4'h8, 4'hF, 8'h00, 4'h0, 4'h0, 0, 0, 8'h20, 8'h22, 8'h3C, 0, 2);
    add(0, 4'h0, 4'hF, 8'h00, 4'h8, 4'h0, 0, 1, 8'h30, 8'h33, 8'h3C, 1, 0);
    add(0, 4'h0, 4'h0, 8'h00, 4'h0, 4'h0, 0, 0, 8'h30, 8'h33, 8'h3C, 0, 0);

    foreach (vecs[i]) begin
      @(posedge Clk); #1;
      Rst             = vecs[i].rst;
      bus.core_req    = vecs[i].req;
      bus.core_we     = vecs[i].we;
      bus.DRAM_dataIn = vecs[i].din;
      @(negedge Clk);
      check($sformatf("vec%0d", i), 64'(obs()), 64'(vecs[i].exp));
    end

    // reset one cycle after memREAD: the read must vanish
    @(posedge Clk); #1;
    bus.core_req = 4'h1; bus.core_we = 4'h0;
    @(posedge Clk); #1;
    bus.core_req = 4'h0;
    @(negedge Clk);
    check("mr_issue", 64'(obs()),
          64'({4'h1, 4'h0, 1'b1, 1'b0, 8'h40, 8'h11, 8'h3C, 2'd1, 2'd1}));
    @(posedge Clk); #1;
    Rst = 1'b1; bus.DRAM_dataIn = 8'h5A;
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    check("mr_reset", 64'(obs()), 64'd0);
    rv_seen = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      rv_seen = rv_seen | bus.core_rvalid;
    end
    check("mr_no_rvalid", 64'(rv_seen), 64'd0);
    check("mr_rdata", 64'(bus.core_rdata), 64'd0);

    // next request after reset is served normally
    @(posedge Clk); #1;
    bus.core_req = 4'h4; bus.core_we = 4'h4;
    @(posedge Clk); #1;
    bus.core_req = 4'h0;
    @(negedge Clk);
    check("post_rst_write", 64'(obs()),
          64'({4'h4, 4'h0, 1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, 2'd1, 2'd3}));

    // read latency measured with a bounded wait
    @(posedge Clk); #1;
    bus.core_req = 4'h8; bus.core_we = 4'h0; bus.DRAM_dataIn = 8'h77;
    lat = 0; got = 1'b0; rv_val = '0; rd_val = '0;
    for (int c = 0; c < 20; c++) begin
      if (!got) begin
        @(posedge Clk); #1;
        bus.core_req = 4'h0;
        lat++;
        @(negedge Clk);
        if (bus.core_rvalid != 4'h0) begin
          got    = 1'b1;
          rv_val = bus.core_rvalid;
          rd_val = bus.core_rdata;
        end
      end
    end
    check("rd_timeout", 64'(got), 64'd1);
    check("rd_latency", 64'(lat), 64'(RL + 2));
    check("rd_rvalid", 64'(rv_val), 64'h8);
    check("rd_rdata", 64'(rd_val), 64'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
